spart_pixel_rx: RTL
===================

# spart_pixel_rx

Receive-side SPART (8N1 UART) pixel deserializer. It recovers bytes from a serial line, pairs them into 12-bit pixels (low byte first), and emits one-cycle pixel strobes with a running pixel index and an end-of-frame pulse. It sits at the far end of the camera frame-capture serial link. A host or loopback bench streams a captured frame back in over `rxd`, and downstream logic (frame buffer writer, checker) consumes `pix_data`/`pix_val`.

## Interface
Parameters:
- `BAUD_DIV`, default 434: CLK cycles per bit (50 MHz / 115200). Must be ≥ 4.
- `FRAME_PIXELS`, default 307200: pixels per frame (640×480).
- `IDLE_BITS`, default 20: bit-times of line idle that discard a half-received pixel.

Ports:
- `CLK` in 1: single system clock; all logic on rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial input; idle high; asynchronous to CLK.
- `pix_data` out 12: assembled pixel; holds its value between strobes.
- `pix_val` out 1: one-cycle strobe; `pix_data` and `pix_idx` are valid while it is high.
- `pix_idx` out 19: index of the current pixel within the frame, 0..FRAME_PIXELS-1.
- `frame_done` out 1: one-cycle pulse, coincident with `pix_val` of pixel FRAME_PIXELS-1.
- `framing_err` out 1: one-cycle pulse when a stop bit is sampled low.
- `sync_err` out 1: one-cycle pulse when the idle timeout discards a pending low byte.

## Operation
- `rxd` passes through a 2-flop synchronizer, reset to 1. All logic below uses the synchronized signal `rxs`.
- Bit FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: `rxs`=0 → START and load `baud_cnt` = BAUD_DIV/2 − 1.
  - START: when `baud_cnt` reaches 0, sample `rxs`. If 0 → DATA (bit_idx=0, reload BAUD_DIV−1). If 1 (glitch) → IDLE with no outputs.
  - DATA: every BAUD_DIV cycles, shift `rxs` into bit[bit_idx], LSB first. After bit 7 → STOP.
  - STOP: sample after BAUD_DIV cycles.
    - If 1 → byte accepted, then IDLE.
    - If 0 → pulse `framing_err`, drop the byte, clear the byte phase, then go to IDLE only after `rxs` is seen high. No new start is detected while the line is held low.
- Byte pairing uses a phase bit `ph`.
  - ph=0: an accepted byte is stored as `lo`, then ph=1.
  - ph=1: `pix_data` = {byte[3:0], lo}. byte[7:4] is ignored. Pulse `pix_val`, then ph=0.
- Pixel counter:
  - `pix_idx` presents the index of the pixel being strobed.
  - It increments the cycle after each `pix_val`.
  - After pixel FRAME_PIXELS-1 it wraps to 0, and `frame_done` pulses with that strobe.
- Idle timeout:
  - Applies while ph=1 and the FSM is in IDLE.
  - The counter runs while `rxs`=1 and resets on any start.
  - At IDLE_BITS×BAUD_DIV cycles: clear ph and pulse `sync_err`.
  - `pix_idx` is unchanged by a timeout.
- Width rules:
  - `baud_cnt` is clog2(BAUD_DIV) bits.
  - The idle counter is clog2(IDLE_BITS×BAUD_DIV+1) bits.
  - `pix_idx` is fixed at 19 bits, and FRAME_PIXELS ≤ 2^19.

## Timing
- Reset values:
  - `pix_data`=0, `pix_val`=0, `pix_idx`=0, `frame_done`=0, `framing_err`=0, `sync_err`=0.
  - FSM=IDLE, ph=0, synchronizer=1.
- Latency:
  - The start edge is seen 2 cycles after `rxd` falls.
  - The stop sample lands at the stop-bit midpoint: start detect + BAUD_DIV/2 + 9×BAUD_DIV cycles.
  - `pix_val` and `framing_err` are registered and assert the cycle after the stop sample.
- No backpressure. The consumer must accept `pix_val` every cycle it asserts. The minimum strobe spacing is 20×BAUD_DIV cycles.
- Back-to-back characters:
  - A start bit immediately after the stop sample is detected, because IDLE is entered in the same cycle the stop is accepted.
  - The receiver tolerates ±4% baud mismatch.
- Simultaneous events: a timeout and a start detect in the same cycle resolve as start wins; the timeout is suppressed.
- Reset asserted mid-character or mid-pixel:
  - All outputs and state clear asynchronously.
  - After release, the receiver waits for `rxs`=1 before it can detect a start. A partially received character is never emitted.

## Test plan
Use BAUD_DIV=8, IDLE_BITS=4, FRAME_PIXELS=4.
- Send bytes 0x34, 0x12 → one `pix_val` with `pix_data`=0x234 and `pix_idx`=0. `pix_val` asserts 1 cycle after the second stop-bit midpoint.
- Send 8 bytes encoding pixels 0x000, 0x001, 0xFFF, 0xABC back to back → 4 strobes with `pix_idx` 0..3, `frame_done` only on the 4th, then `pix_idx`=0. The 5th pixel gets `pix_idx`=0.
- Hold the stop bit low on the second byte → `framing_err` pulses once and no `pix_val`. The next valid pair 0x01, 0x00 yields 0x001.
- Send a 2-cycle low glitch on idle `rxd` → no outputs and FSM back in IDLE. The following byte pair decodes normally.
- Send a single byte 0x55, then idle 32+ cycles → `sync_err` pulses at 32 cycles. The next pair 0x78, 0x06 yields 0x678 with `pix_idx` unchanged.
- Assert `RST_N` low during DATA bit 4 of the second byte → all outputs 0. After release, a fresh pair 0x22, 0x01 yields 0x122 with `pix_idx`=0.

Source files
------------

// File: rtl/spart_pixel_rx.sv
// 8N1 serial receiver that pairs bytes (low byte first) into 12-bit pixels
// and emits pixel strobes with a running frame index.
module spart_pixel_rx #(
  parameter int BAUD_DIV     = 434,
  parameter int FRAME_PIXELS = 307200,
  parameter int IDLE_BITS    = 20
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        rxd,
  output logic [11:0] pix_data,
  output logic        pix_val,
  output logic [18:0] pix_idx,
  output logic        frame_done,
  output logic        framing_err,
  output logic        sync_err
);

  // state   | meaning
  // S_IDLE  | line idle, waiting for a falling edge (once the line has been seen high)
  // S_START | timing to the start-bit midpoint to reject glitches
  // S_DATA  | sampling 8 data bits, LSB first, one per bit time
  // S_STOP  | sampling stop bit; on a low stop, waits here for the line to return high
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int BW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(IDLE_BITS * BAUD_DIV + 1);
  localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LOAD  = BW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_BITS * BAUD_DIV - 1);
  localparam logic [18:0]   LAST_IDX  = 19'(FRAME_PIXELS - 1);

  logic          rx_meta;
  logic          rxs;
  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          brk;
  logic          armed;
  logic          ph;
  logic [7:0]    lo;
  logic [IW-1:0] idle_cnt;

  logic baud_tc;
  logic start_det;
  logic stop_ok;
  logic stop_bad;
  logic idle_run;
  logic timeout;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_comb begin
    baud_tc   = (baud_cnt == '0);
    start_det = (state == S_IDLE) && armed && !rxs;
    stop_ok   = (state == S_STOP) && !brk && baud_tc && rxs;
    stop_bad  = (state == S_STOP) && !brk && baud_tc && !rxs;
    idle_run  = (state == S_IDLE) && ph && rxs;
    // a start in the same cycle always suppresses the timeout
    timeout   = idle_run && (idle_cnt == '0) && !start_det;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      brk      <= 1'b0;
      armed    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!armed) begin
            armed <= rxs;
          end else if (!rxs) begin
            state    <= S_START;
            baud_cnt <= HALF_LOAD;
          end
        end
        S_START: begin
          if (baud_tc) begin
            if (!rxs) begin
              state    <= S_DATA;
              bit_idx  <= '0;
              baud_cnt <= BIT_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_tc) begin
            shreg[bit_idx] <= rxs;
            baud_cnt       <= BIT_LOAD;
            if (bit_idx == 3'd7) state <= S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          if (brk) begin
            if (rxs) begin
              brk   <= 1'b0;
              state <= S_IDLE;
            end
          end else if (baud_tc) begin
            if (rxs) state <= S_IDLE;
            else     brk   <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // idle timeout: down-counter held at its load value whenever it is not running
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idle_cnt <= IDLE_LOAD;
    end else if (!idle_run || start_det) begin
      idle_cnt <= IDLE_LOAD;
    end else if (idle_cnt != '0) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ph          <= 1'b0;
      lo          <= '0;
      pix_data    <= '0;
      pix_val     <= 1'b0;
      pix_idx     <= '0;
      frame_done  <= 1'b0;
      framing_err <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pix_val     <= 1'b0;
      frame_done  <= 1'b0;
      framing_err <= 1'b0;
      sync_err    <= 1'b0;
      if (pix_val) begin
        pix_idx <= (pix_idx == LAST_IDX) ? '0 : pix_idx + 19'd1;
      end
      if (stop_ok) begin
        if (!ph) begin
          lo <= shreg;
          ph <= 1'b1;
        end else begin
          pix_data   <= {shreg[3:0], lo};
          pix_val    <= 1'b1;
          frame_done <= (pix_idx == LAST_IDX);
          ph         <= 1'b0;
        end
      end
      if (stop_bad) begin
        framing_err <= 1'b1;
        ph          <= 1'b0;
      end
      if (timeout) begin
        sync_err <= 1'b1;
        ph       <= 1'b0;
      end
    end
  end

endmodule
